// File: rtl/alu_pkg.sv
// Shared types for alu_mc: opcodes, flag bit positions, FSM states and
// the per-opcode flag-enable table.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_XOR    = 4'd2,
    OP_SLL    = 4'd4,
    OP_SRA    = 4'd5,
    OP_ROR    = 4'd6,
    OP_PADDSB = 4'd7,
    OP_MUL    = 4'd8
  } opcode_e;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Which flags an opcode may write, returned as {zen, ven, nen}.
  function automatic logic [2:0] flag_en(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL:         flag_en = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_en = 3'b100;
      default:                        flag_en = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/alu_mc_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// done_c/product_c present the final product in the cycle of the last step.
module mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic                 busy_q, busy_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       sum_c;

  // prod holds {partial sum, remaining multiplier bits}; shifts right each step.
  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    sum_c   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    if (!busy_q) begin
      if (start) begin
        busy_d  = 1'b1;
        count_d = CW'(WIDTH);
        mcand_d = a;
        prod_d  = {{WIDTH{1'b0}}, b};
      end
    end else begin
      if (count_q != '0) begin
        count_d = count_q - CW'(1);
        prod_d  = {sum_c, prod_q[WIDTH-1:1]};
      end
      if ((count_d == '0) && !hold) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      count_q <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign busy      = busy_q;
  assign done_c    = busy_q && (count_q <= CW'(1));
  assign product_c = prod_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshake, registered
// result/flags, saturating arithmetic and an iterative MUL.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);

  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned LANES = WIDTH / 4;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [2:0]           flags_q, flags_d;

  opcode_e              op_c;
  logic [SHW-1:0]       sh_c;
  logic [WIDTH-1:0]     sum_c, diff_c, alu_res_c;
  logic                 add_ovf_c, sub_ovf_c, alu_v_c;
  logic [2*WIDTH-1:0]   ror_c;
  logic [4:0]           lane_c;

  logic                 slot_free_c, accept_c, mul_start_c;
  logic                 mul_busy, mul_done_c;
  logic [2*WIDTH-1:0]   mul_prod_c;
  logic                 wr_c;
  logic [WIDTH-1:0]     wr_res_c;
  logic [2:0]           wr_flg_c, wr_en_c;

  // Single-cycle datapath: saturating add/sub, logic, shifts, nibble adder.
  always_comb begin
    op_c      = opcode_e'(opcode);
    sh_c      = b[SHW-1:0];
    sum_c     = a + b;
    diff_c    = a - b;
    add_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
    sub_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
    ror_c     = {a, a} >> sh_c;
    alu_res_c = '0;
    alu_v_c   = 1'b0;
    lane_c    = '0;
    case (op_c)
      OP_ADD: begin
        alu_res_c = add_ovf_c ? (a[WIDTH-1] ? SMIN : SMAX) : sum_c;
        alu_v_c   = add_ovf_c;
      end
      OP_SUB: begin
        alu_res_c = sub_ovf_c ? (a[WIDTH-1] ? SMIN : SMAX) : diff_c;
        alu_v_c   = sub_ovf_c;
      end
      OP_XOR: alu_res_c = a ^ b;
      OP_SLL: alu_res_c = a << sh_c;
      OP_SRA: alu_res_c = WIDTH'($signed(a) >>> sh_c);
      OP_ROR: alu_res_c = ror_c[WIDTH-1:0];
      OP_PADDSB: begin
        // Sign-extended 5-bit lane sum; bits 4 and 3 differ on overflow.
        for (int i = 0; i < LANES; i++) begin
          lane_c = {a[4*i+3], a[4*i +: 4]} + {b[4*i+3], b[4*i +: 4]};
          if (lane_c[4] != lane_c[3]) begin
            alu_res_c[4*i +: 4] = lane_c[4] ? 4'h8 : 4'h7;
          end else begin
            alu_res_c[4*i +: 4] = lane_c[3:0];
          end
        end
      end
      default: alu_res_c = '0;
    endcase
  end

  // Control FSM: accept, launch MUL, write result slot, flag update.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    slot_free_c = !out_valid_q || out_ready;
    in_ready    = (state_q == ST_IDLE) && slot_free_c;
    accept_c    = in_valid && in_ready;
    mul_start_c = 1'b0;
    wr_c        = 1'b0;
    wr_res_c    = alu_res_c;
    wr_flg_c    = '0;
    wr_en_c     = '0;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (op_c == OP_MUL) begin
            mul_start_c = 1'b1;
            state_d     = ST_BUSY;
          end else begin
            wr_c             = 1'b1;
            wr_res_c         = alu_res_c;
            wr_flg_c[FLAG_Z] = (alu_res_c == '0);
            wr_flg_c[FLAG_V] = alu_v_c;
            wr_flg_c[FLAG_N] = alu_res_c[WIDTH-1];
            wr_en_c          = flag_en(op_c);
          end
        end
      end
      ST_BUSY: begin
        if (mul_busy && mul_done_c && slot_free_c) begin
          wr_c             = 1'b1;
          wr_res_c         = mul_prod_c[WIDTH-1:0];
          wr_flg_c[FLAG_Z] = (mul_prod_c[WIDTH-1:0] == '0);
          wr_flg_c[FLAG_V] = |mul_prod_c[2*WIDTH-1:WIDTH];
          wr_flg_c[FLAG_N] = mul_prod_c[WIDTH-1];
          wr_en_c          = flag_en(OP_MUL);
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wr_c) begin
      result_d    = wr_res_c;
      out_valid_d = 1'b1;
      flags_d     = (flags_q & ~wr_en_c) | (wr_flg_c & wr_en_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start_c),
    .hold      (!slot_free_c),
    .a         (a),
    .b         (b),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc against an arithmetic reference
// model and an in-order result scoreboard.
module tb_alu_mc;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic [2:0]   flg;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [2:0]    flags;

  int            n_checks = 0;
  int            n_fail = 0;
  int            n_deliv = 0;
  exp_t          exp_q[$];
  logic [2:0]    model_flags = '0;

  logic          seen_ov, seen_ir, seen_acc;
  logic [W-1:0]  seen_res;
  logic [2:0]    seen_flg;

  logic [3:0]    legal_ops [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
  logic [W-1:0]  edge_vals [6] = '{16'h0000, 16'h0001, 16'h7fff, 16'h8000, 16'hffff, 16'h0100};

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the operation rules, using wide integers.
  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] va,
                                 input logic [W-1:0] vb, input logic [2:0] fin,
                                 output logic [W-1:0] res, output logic [2:0] fout);
    longint hi = (longint'(1) << (W - 1)) - 1;
    longint lo = -(longint'(1) << (W - 1));
    longint sa, sb, s, u, p;
    int     sh, x, y, z;
    logic   v;
    sa   = longint'($signed(va));
    sb   = longint'($signed(vb));
    u    = longint'(va);
    sh   = int'(vb) % W;
    res  = '0;
    fout = fin;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? sa + sb : sa - sb;
        v = 1'b0;
        if (s > hi) begin s = hi; v = 1'b1; end
        else if (s < lo) begin s = lo; v = 1'b1; end
        res  = W'(s);
        fout = {s == 0, v, s < 0};
      end
      4'd2: begin res = va ^ vb; fout[2] = (res == '0); end
      4'd4: begin res = W'(u << sh); fout[2] = (res == '0); end
      4'd5: begin res = W'(sa >>> sh); fout[2] = (res == '0); end
      4'd6: begin res = W'((u >> sh) | (u << (W - sh))); fout[2] = (res == '0); end
      4'd7: begin
        for (int i = 0; i < W / 4; i++) begin
          x = int'(va[4*i +: 4]); if (x > 7) x -= 16;
          y = int'(vb[4*i +: 4]); if (y > 7) y -= 16;
          z = x + y;
          if (z > 7) z = 7;
          if (z < -8) z = -8;
          res[4*i +: 4] = 4'(z);
        end
      end
      4'd8: begin
        p    = u * longint'(vb);
        res  = W'(p);
        fout = {res == '0, (p >> W) != 0, res[W-1]};
      end
      default: res = '0;
    endcase
  endfunction

  // One clock: sample at negedge, score outputs, record accepts, then move past posedge.
  task automatic step();
    exp_t e;
    logic [W-1:0] r;
    logic [2:0]   f;
    @(negedge clk);
    seen_ov  = out_valid;
    seen_ir  = in_ready;
    seen_res = result;
    seen_flg = flags;
    seen_acc = in_valid && in_ready;
    if (out_valid) begin
      check_eq("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check_eq("result", result, exp_q[0].res);
        check_eq("flags", flags, exp_q[0].flg);
        if (out_ready) begin
          e = exp_q.pop_front();
          n_deliv++;
        end
      end
    end
    if (seen_acc) begin
      ref_op(opcode, a, b, model_flags, r, f);
      model_flags = f;
      exp_q.push_back(exp_t'{res: r, flg: f});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    model_flags = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", flags, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    int n;
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!seen_acc && n < 100);
    check_eq("accepted", seen_acc, 1);
    in_valid = 1'b0;
    // Scramble operands after accept; they must not affect the result.
    opcode = 4'($urandom);
    a      = W'($urandom);
    b      = W'($urandom);
  endtask

  task automatic wait_done(output int lat, output int irl);
    lat = 0;
    irl = 0;
    do begin
      step();
      lat++;
      if (!seen_ir) irl++;
    end while (!seen_ov && lat < 100);
    check_eq("done_seen", seen_ov, 1);
  endtask

  initial begin
    int lat, irl, d0;
    logic [W-1:0] va, vb;

    do_reset();

    issue(4'd0, 16'h7fff, 16'h0001);
    wait_done(lat, irl);
    check_eq("add_lat", lat, 1);
    check_eq("add_res", seen_res, 16'h7fff);
    check_eq("add_flg", seen_flg, 3'b010);

    issue(4'd1, 16'h0005, 16'h0005);
    wait_done(lat, irl);
    check_eq("sub_res", seen_res, 16'h0000);
    check_eq("sub_flg", seen_flg, 3'b100);
    issue(4'd2, 16'hffff, 16'h0000);
    wait_done(lat, irl);
    check_eq("xor_res", seen_res, 16'hffff);
    check_eq("xor_flg", seen_flg, 3'b000);

    issue(4'd8, 16'h0100, 16'h0100);
    wait_done(lat, irl);
    check_eq("mul_lat", lat, W + 1);
    check_eq("mul_in_ready_low", irl, W);
    check_eq("mul_res", seen_res, 16'h0000);
    check_eq("mul_flg", seen_flg, 3'b110);

    issue(4'd1, 16'h0000, 16'h0001);
    wait_done(lat, irl);
    check_eq("sub_neg_flg", seen_flg, 3'b001);
    issue(4'd7, 16'h7777, 16'h1111);
    wait_done(lat, irl);
    check_eq("paddsb_res", seen_res, 16'h7777);
    check_eq("paddsb_flg", seen_flg, 3'b001);

    // Back-to-back XORs under backpressure.
    d0 = n_deliv;
    out_ready = 1'b0;
    issue(4'd2, 16'h1234, 16'h00ff);
    opcode = 4'd2; a = 16'ha5a5; b = 16'h5a5a; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_in_ready", seen_ir, 0);
      check_eq("stall_result", seen_res, 16'h12cb);
    end
    out_ready = 1'b1;
    step();
    check_eq("stall_release_accept", seen_acc, 1);
    in_valid = 1'b0;
    step();
    check_eq("stall_last_res", seen_res, 16'hffff);
    check_eq("stall_deliveries", n_deliv - d0, 2);

    // Reset while MUL is mid-count.
    issue(4'd8, 16'h1234, 16'h5678);
    repeat (6) step();
    do_reset();
    issue(4'd0, 16'h0001, 16'h0002);
    wait_done(lat, irl);
    check_eq("post_rst_add", seen_res, 16'h0003);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || seen_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) < 8) opcode = legal_ops[$urandom_range(0, 7)];
        else opcode = 4'($urandom);
        va = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
        vb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
        a = va;
        b = vb;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 5) step();
    check_eq("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
